// File: rtl/nvr_fetch_ctrl_if.sv
// nvr_fetch_ctrl_if: bundles the Controller-side fetch handshake and the
// NVR_TOP macro pins driven or observed by nvr_fetch_ctrl.
// The "slave" modport is the fetch controller itself; the "master" modport
// is the surrounding environment (Controller plus NVR macro).
interface nvr_fetch_ctrl_if #(
  parameter int ADDR_W = 7
);
  // Controller side
  logic [31:0]       pc_addr;
  logic              fetch_req;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              stall;
  logic              err;
  // NVR_TOP side
  logic [ADDR_W-1:0] nvr_a;
  logic              nvr_ce;
  logic              nvr_por;
  logic              nvr_rdy;
  logic [31:0]       nvr_dout;

  modport master (
    output pc_addr,
    output fetch_req,
    output nvr_rdy,
    output nvr_dout,
    input  instr,
    input  instr_valid,
    input  stall,
    input  err,
    input  nvr_a,
    input  nvr_ce,
    input  nvr_por
  );

  modport slave (
    input  pc_addr,
    input  fetch_req,
    input  nvr_rdy,
    input  nvr_dout,
    output instr,
    output instr_valid,
    output stall,
    output err,
    output nvr_a,
    output nvr_ce,
    output nvr_por
  );
endinterface

// File: rtl/nvr_fetch_ctrl.sv
// nvr_fetch_ctrl: instruction fetch sequencer for the NVR_TOP macro.
// After reset it runs a POR assert/settle sequence, then serves fetch
// requests with a CE strobe and waits for a synchronised rising edge on RDY
// before capturing DOUT. A RDY edge that never arrives parks the block in a
// sticky error state that only reset clears.
// Optional feature: define NVR_FETCH_BUF_EN to add a one-entry fetch buffer
// (tag, data, valid) that answers repeat fetches of the last captured word
// without touching the macro. Default build has no buffer logic.
module nvr_fetch_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int POR_CYC     = 4,
  parameter int CE_CYC      = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           reset,
  nvr_fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    POR_ASSERT = 3'd0,
    POR_WAIT   = 3'd1,
    IDLE       = 3'd2,
    CE_HIGH    = 3'd3,
    WAIT_RDY   = 3'd4,
    ERROR      = 3'd5
  } state_t;

  // One shared phase counter serves POR, CE and timeout timing, so it is
  // sized for the longest of the three.
  localparam int CNT_M1  = (POR_CYC > CE_CYC) ? POR_CYC : CE_CYC;
  localparam int CNT_MAX = (CNT_M1 > TIMEOUT_CYC) ? CNT_M1 : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] CE_LAST  = CNT_W'(CE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               accept;
  logic               capture;
  logic               timeout;

  logic               rdy_p0;
  logic               rdy_p1;
  logic               rdy_p2;
  logic               rdy_rise;

  // Upper PC bits are outside the NVR word space and intentionally ignored.
  logic               unused_pc_bits;
  assign unused_pc_bits = ^bus.pc_addr[31:ADDR_W];

`ifdef NVR_FETCH_BUF_EN
  logic [ADDR_W-1:0]  buf_tag;
  logic [31:0]        buf_data;
  logic               buf_vld;
  logic               buf_match;
  logic               hit;

  assign buf_match = buf_vld && (buf_tag == bus.pc_addr[ADDR_W-1:0]);
`endif

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous RDY ----
  // ---- stage p2: delayed copy used only for rising-edge detection ----
  // Synchronise RDY into clk and keep one extra flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_p0 <= 1'b0;
      rdy_p1 <= 1'b0;
      rdy_p2 <= 1'b0;
    end else begin
      rdy_p0 <= bus.nvr_rdy;
      rdy_p1 <= rdy_p0;
      rdy_p2 <= rdy_p1;
    end
  end

  assign rdy_rise = rdy_p1 & ~rdy_p2;

  // State and phase-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= POR_ASSERT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and phase-counter logic; RDY edges only matter in WAIT_RDY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
`ifdef NVR_FETCH_BUF_EN
    hit       = 1'b0;
`endif
    case (state)
      POR_ASSERT: begin
        if (cnt == POR_LAST) begin
          state_nxt = POR_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      POR_WAIT: begin
        if (cnt == POR_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE: begin
        if (bus.fetch_req) begin
          accept = 1'b1;
`ifdef NVR_FETCH_BUF_EN
          if (buf_match) begin
            hit = 1'b1;
          end else begin
            state_nxt = CE_HIGH;
            cnt_nxt   = '0;
          end
`else
          state_nxt = CE_HIGH;
          cnt_nxt   = '0;
`endif
        end
      end
      CE_HIGH: begin
        if (cnt == CE_LAST) begin
          state_nxt = WAIT_RDY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_RDY: begin
        // A late edge on the final allowed cycle still wins over timeout.
        if (rdy_rise) begin
          capture   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ERROR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = POR_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Address latch, instruction capture, valid pulse and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.nvr_a       <= '0;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.instr_valid <= 1'b0;
      if (accept) begin
        bus.nvr_a <= bus.pc_addr[ADDR_W-1:0];
      end
      if (capture) begin
        bus.instr       <= bus.nvr_dout;
        bus.instr_valid <= 1'b1;
      end
`ifdef NVR_FETCH_BUF_EN
      if (hit) begin
        bus.instr       <= buf_data;
        bus.instr_valid <= 1'b1;
      end
`endif
      if (timeout) begin
        bus.err <= 1'b1;
      end
    end
  end

`ifdef NVR_FETCH_BUF_EN
  // Buffer valid bit: cleared by reset, set by every capture from the macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_vld <= 1'b0;
    end else if (capture) begin
      buf_vld <= 1'b1;
    end
  end

  // Buffer tag/data payload: refilled on every capture, no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_tag  <= bus.nvr_a;
      buf_data <= bus.nvr_dout;
    end
  end
`endif

  // Macro strobes decode straight from state so reset drops CE at once.
  assign bus.nvr_por = (state == POR_ASSERT);
  assign bus.nvr_ce  = (state == CE_HIGH);

  // The Controller is held during POR and after a timeout regardless of
  // fetch_req; otherwise it stalls until the requested word is presented.
  assign bus.stall = (state == POR_ASSERT) || (state == POR_WAIT) ||
                     (state == ERROR) || (bus.fetch_req && !bus.instr_valid);

endmodule

// File: tb/tb_nvr_fetch_ctrl.sv
// tb_nvr_fetch_ctrl: directed bench for nvr_fetch_ctrl with default
// parameters. Buffer-specific vectors are compiled in only when
// NVR_FETCH_BUF_EN is defined, matching the build of the design.
module tb_nvr_fetch_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  nvr_fetch_ctrl_if #(.ADDR_W(7)) bus ();

  nvr_fetch_ctrl #(
    .ADDR_W      (7),
    .POR_CYC     (4),
    .CE_CYC      (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset mid-cycle and follow the POR sequence edge by edge.
  task automatic por_sequence(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("%s_por_k%0d", tag, k), {31'd0, bus.nvr_por}, (k <= 3) ? 32'd1 : 32'd0);
      check($sformatf("%s_stall_k%0d", tag, k), {31'd0, bus.stall}, (k <= 7) ? 32'd1 : 32'd0);
      check($sformatf("%s_vld_k%0d", tag, k), {31'd0, bus.instr_valid}, 32'd0);
    end
  endtask

  // Tick until instr_valid, bounded; n is the number of edges consumed.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick();
      n++;
      if (bus.instr_valid) break;
    end
    if (!bus.instr_valid) n = -1;
  endtask

  // Full macro read: one-cycle request, CE checks, RDY raised 'delay'
  // cycles after CE falls, capture expected 3 edges after RDY rises.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] data, input int delay);
    int n;
    bus.pc_addr   = addr;
    bus.nvr_dout  = data;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check({tag, "_a"}, {25'd0, bus.nvr_a}, addr & 32'h7f);
    check({tag, "_ce_c1"}, {31'd0, bus.nvr_ce}, 32'd1);
    tick();
    check({tag, "_ce_c2"}, {31'd0, bus.nvr_ce}, 32'd1);
    tick();
    check({tag, "_ce_off"}, {31'd0, bus.nvr_ce}, 32'd0);
    repeat (delay) tick();
    bus.nvr_rdy = 1'b1;
    wait_valid(10, n);
    check({tag, "_rdy_lat"}, n, 32'd3);
    check({tag, "_instr"}, bus.instr, data);
    bus.nvr_rdy = 1'b0;
    tick();
    check({tag, "_pulse"}, {31'd0, bus.instr_valid}, 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int seen;
    n_chk  = 0;
    n_fail = 0;
    reset          = 1'b1;
    bus.pc_addr    = 32'd0;
    bus.fetch_req  = 1'b0;
    bus.nvr_rdy    = 1'b0;
    bus.nvr_dout   = 32'd0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_por",   {31'd0, bus.nvr_por},     32'd1);
    check("rst_ce",    {31'd0, bus.nvr_ce},      32'd0);
    check("rst_a",     {25'd0, bus.nvr_a},       32'd0);
    check("rst_instr", bus.instr,                32'd0);
    check("rst_vld",   {31'd0, bus.instr_valid}, 32'd0);
    check("rst_err",   {31'd0, bus.err},         32'd0);
    check("rst_stall", {31'd0, bus.stall},       32'd1);
    repeat (3) @(posedge clk);
    por_sequence("por1");

    // Basic read of word 5, RDY two cycles after CE falls
    do_read("rd5", 32'h0000_0005, 32'h0050_0093, 2);

    // Reset during CE_HIGH aborts the read
    bus.pc_addr   = 32'h0000_0009;
    bus.nvr_dout  = 32'hdead_beef;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check("abort_ce_pre", {31'd0, bus.nvr_ce}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_ce",    {31'd0, bus.nvr_ce},      32'd0);
    check("abort_por",   {31'd0, bus.nvr_por},     32'd1);
    check("abort_vld",   {31'd0, bus.instr_valid}, 32'd0);
    check("abort_a",     {25'd0, bus.nvr_a},       32'd0);
    check("abort_stall", {31'd0, bus.stall},       32'd1);
    repeat (2) @(posedge clk);
    por_sequence("por2");

    // pc_addr changes mid-read; nvr_a must hold, then the next request reads 6
    bus.pc_addr   = 32'h0000_0005;
    bus.nvr_dout  = 32'h1111_1111;
    bus.fetch_req = 1'b1;
    tick();
    check("hold_a_acc", {25'd0, bus.nvr_a}, 32'd5);
    tick();
    tick();
    bus.pc_addr = 32'h0000_0006;
    #1;
    check("hold_a_wait", {25'd0, bus.nvr_a}, 32'd5);
    check("hold_stall",  {31'd0, bus.stall}, 32'd1);
    bus.nvr_rdy = 1'b1;
    wait_valid(10, n);
    check("hold_lat",   n, 32'd3);
    check("hold_instr", bus.instr, 32'h1111_1111);
    check("hold_stall_vld", {31'd0, bus.stall}, 32'd0);
    bus.nvr_rdy  = 1'b0;
    bus.nvr_dout = 32'h0060_0113;
    tick();
    check("next_a",  {25'd0, bus.nvr_a},  32'd6);
    check("next_ce", {31'd0, bus.nvr_ce}, 32'd1);
    bus.fetch_req = 1'b0;
    tick();
    tick();
    bus.nvr_rdy = 1'b1;
    wait_valid(10, n);
    check("next_lat",   n, 32'd3);
    check("next_instr", bus.instr, 32'h0060_0113);
    bus.nvr_rdy = 1'b0;
    repeat (4) tick();

`ifdef NVR_FETCH_BUF_EN
    // Buffer: miss on 5, hit on 5 one cycle later without CE, miss on 6
    do_read("buf_fill", 32'h0000_0005, 32'h0050_0093, 0);
    bus.pc_addr   = 32'h0000_0005;
    bus.nvr_dout  = 32'h0bad_0bad;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check("buf_hit_vld",   {31'd0, bus.instr_valid}, 32'd1);
    check("buf_hit_instr", bus.instr,                32'h0050_0093);
    check("buf_hit_ce",    {31'd0, bus.nvr_ce},      32'd0);
    tick();
    check("buf_hit_pulse", {31'd0, bus.instr_valid}, 32'd0);
    check("buf_hit_ce2",   {31'd0, bus.nvr_ce},      32'd0);
    do_read("buf_miss6", 32'h0000_0006, 32'h0060_0113, 0);
`endif

    // RDY held high: no edge, timeout after 64 cycles in WAIT_RDY
    bus.nvr_rdy = 1'b1;
    repeat (4) tick();
    bus.pc_addr   = 32'h0000_0010;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    seen = 0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (bus.instr_valid) seen = 1;
      if (k == 65) check("tmo_err_early", {31'd0, bus.err}, 32'd0);
    end
    check("tmo_err",      {31'd0, bus.err},   32'd1);
    check("tmo_stall",    {31'd0, bus.stall}, 32'd1);
    check("tmo_no_valid", seen,               32'd0);

    // RDY edge while in ERROR is ignored; error stays sticky
    bus.nvr_rdy = 1'b0;
    repeat (3) tick();
    bus.nvr_rdy   = 1'b1;
    bus.fetch_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.instr_valid) seen = 1;
    end
    bus.fetch_req = 1'b0;
    #1;
    check("err_sticky",     {31'd0, bus.err},   32'd1);
    check("err_stall",      {31'd0, bus.stall}, 32'd1);
    check("err_no_capture", seen,               32'd0);

    // Only reset leaves ERROR
    reset = 1'b0;
    #1;
    check("err_rst_err",   {31'd0, bus.err},     32'd0);
    check("err_rst_por",   {31'd0, bus.nvr_por}, 32'd1);
    check("err_rst_stall", {31'd0, bus.stall},   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nvr_fetch_ctrl.md
NVR_FETCH_CTRL -- requirements
Module: nvr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7: width of the NVR word address.
REQ-002 Parameter POR_CYC, default 4: clk cycles for each POR phase (assert, then settle).
REQ-003 Parameter CE_CYC, default 2: clk cycles nvr_ce is held high per read.
REQ-004 Parameter TIMEOUT_CYC, default 64: clk cycles allowed in WAIT_RDY before error.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 pc_addr  input  32: fetch address from the Controller; the word index is pc_addr[ADDR_W-1:0].
REQ-008 fetch_req  input  1: Controller requests an instruction at pc_addr.
REQ-009 instr  output  32: last captured instruction word.
REQ-010 instr_valid  output  1: one-cycle pulse; instr is new this cycle.
REQ-011 stall  output  1: Controller holds PC while high.
REQ-012 err  output  1: sticky RDY-timeout flag.
REQ-013 nvr_a  output  ADDR_W: address to NVR_TOP.A.
REQ-014 nvr_ce  output  1: NVR_TOP.CE read strobe.
REQ-015 nvr_por  output  1: NVR_TOP.POR.
REQ-016 nvr_rdy  input  1: NVR_TOP.RDY, asynchronous to clk.
REQ-017 nvr_dout  input  32: NVR_TOP.DOUT.

Function
REQ-018 The FSM states SHALL be POR_ASSERT, POR_WAIT, IDLE, CE_HIGH, WAIT_RDY and ERROR.
REQ-019 POR_ASSERT SHALL drive nvr_por=1 for POR_CYC cycles and then go to POR_WAIT, which drives nvr_por=0 for POR_CYC cycles and then goes to IDLE.
REQ-020 When fetch_req=1 in IDLE, the block SHALL latch pc_addr[ADDR_W-1:0] into nvr_a and go to CE_HIGH on the next edge.
REQ-021 CE_HIGH SHALL drive nvr_ce=1 for exactly CE_CYC cycles and then go to WAIT_RDY with nvr_ce=0.
REQ-022 nvr_rdy SHALL pass through a 2-flop synchroniser; capture SHALL occur only on a synchronised 0->1 edge seen while in WAIT_RDY.
REQ-023 On capture, instr SHALL take nvr_dout, instr_valid SHALL pulse high for 1 cycle, and the FSM SHALL return to IDLE.
REQ-024 Minimum latency from fetch_req acceptance to instr_valid SHALL be CE_CYC+3 cycles, and one additional cycle per cycle of RDY delay.
REQ-025 stall SHALL equal fetch_req AND NOT instr_valid, and SHALL be forced to 1 in POR_ASSERT, POR_WAIT and ERROR.
REQ-026 nvr_a SHALL hold its latched value from IDLE exit until the next acceptance, even if pc_addr changes mid-read.
REQ-027 fetch_req is not required to stay asserted after acceptance; the read SHALL complete and instr_valid SHALL still pulse.
REQ-028 After TIMEOUT_CYC cycles in WAIT_RDY with no RDY edge, the FSM SHALL enter ERROR and set err=1; only reset SHALL exit ERROR.
REQ-029 An RDY edge arriving outside WAIT_RDY SHALL be ignored.

Reset
REQ-030 reset low SHALL immediately set state=POR_ASSERT, nvr_por=1, nvr_ce=0, nvr_a=0, instr=0, instr_valid=0, err=0, all counters and synchroniser flops to 0, and stall=1.
REQ-031 Reset asserted mid-read SHALL abort the read with no instr_valid pulse, and the POR sequence SHALL restart on release.

Configuration
REQ-032 With macro NVR_FETCH_BUF_EN defined, the block SHALL keep a one-entry buffer (tag, data, valid). A fetch_req in IDLE whose word index matches the valid tag SHALL produce instr_valid on the next cycle with no nvr_ce pulse. Every capture SHALL refill the buffer, and reset SHALL invalidate it.
REQ-033 Without NVR_FETCH_BUF_EN, every accepted request SHALL perform a full CE/RDY read, and no buffer logic SHALL be present.

Verification
REQ-034 Release reset with defaults -> nvr_por high 4 cycles, low 4 cycles; IDLE reached at cycle 8; stall=1 throughout.
REQ-035 fetch_req with pc_addr=0x05, RDY rising 2 cycles after CE falls, nvr_dout=0x00500093 -> nvr_a=5, nvr_ce high 2 cycles, instr=0x00500093, single instr_valid pulse.
REQ-036 RDY held permanently high -> no capture; ERROR after 64 cycles in WAIT_RDY; err=1 and stall=1 until reset.
REQ-037 pc_addr changes from 0x05 to 0x06 during WAIT_RDY -> nvr_a stays 5; next request reads 6.
REQ-038 Reset pulsed low during CE_HIGH -> nvr_ce=0 immediately, no instr_valid, POR sequence reruns.
REQ-039 With NVR_FETCH_BUF_EN: two back-to-back fetches of 0x05 -> second gives instr_valid 1 cycle after request with no nvr_ce activity; a fetch of 0x06 performs a full read.
